// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Modulo-2^32 address arithmetic; alignment is deliberately not checked.
  function automatic logic [XLEN-1:0] pc_plus(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/fetch_ctrl_skid.sv
// One-entry instruction/PC buffer that parks a fetched word while F/D is stalled.
module fetch_ctrl_skid
  import fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the IM request and feeds the F/D register.
// Build option FETCH_DELAY_SLOT_EN: redirects keep the delay slot; otherwise they squash it.
//
// state  | meaning
// S_RST  | one cycle after reset, no request
// S_REQ  | IM request outstanding at pc
// S_HOLD | fetched word parked in the skid while F/D is stalled
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redir_valid,
  input  logic [XLEN-1:0]    redir_target,
  output logic               im_req,
  output logic [XLEN-1:0]    im_addr,
  input  logic               im_ready,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pc8
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               redir_pend_q, redir_pend_d;
  logic [XLEN-1:0]    redir_tgt_q, redir_tgt_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0]    if_pc_q, if_pc_d;
`ifndef FETCH_DELAY_SLOT_EN
  logic               drop_q, drop_d;
`endif

  logic               skid_load, skid_unload, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [XLEN-1:0]    skid_pc;

  logic               redir_acc, out_free;
  logic [XLEN-1:0]    next_pc;

  assign redir_acc = redir_valid && !stall_i;
  assign out_free  = !if_valid_q || !stall_i;
  // A redirect accepted in the same cycle as next_pc is used bypasses the pending target.
  assign next_pc   = redir_acc    ? redir_target :
                     redir_pend_q ? redir_tgt_q  : pc_plus(pc_q, 32'd4);

  fetch_ctrl_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .instr_i  (im_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
`ifndef FETCH_DELAY_SLOT_EN
    drop_d       = drop_q;
`endif

    if (if_valid_q && !stall_i) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      S_RST: begin
        // D stage is empty coming out of reset, so redirects here are ignored.
        state_d = S_REQ;
      end

      S_REQ: begin
        if (im_ready) begin
`ifdef FETCH_DELAY_SLOT_EN
          if (out_free) begin
            if_valid_d   = 1'b1;
            if_instr_d   = im_rdata;
            if_pc_d      = pc_q;
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
`else
          if (drop_q || redir_acc) begin
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
            drop_d       = 1'b0;
          end else if (out_free) begin
            if_valid_d   = 1'b1;
            if_instr_d   = im_rdata;
            if_pc_d      = pc_q;
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
`endif
        end else if (redir_acc) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = redir_target;
`ifndef FETCH_DELAY_SLOT_EN
          drop_d       = 1'b1;
`endif
        end
      end

      S_HOLD: begin
        if (!stall_i && skid_valid) begin
          skid_unload  = 1'b1;
          pc_d         = next_pc;
          redir_pend_d = 1'b0;
          state_d      = S_REQ;
`ifdef FETCH_DELAY_SLOT_EN
          if_valid_d   = 1'b1;
          if_instr_d   = skid_instr;
          if_pc_d      = skid_pc;
`else
          if (!redir_acc) begin
            if_valid_d = 1'b1;
            if_instr_d = skid_instr;
            if_pc_d    = skid_pc;
          end
`endif
        end
      end

      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_RST;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
`ifndef FETCH_DELAY_SLOT_EN
      drop_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
`ifndef FETCH_DELAY_SLOT_EN
      drop_q       <= drop_d;
`endif
    end
  end

  // Request side comes from registered state only.
  assign im_req   = (state_q == S_REQ);
  assign im_addr  = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_pc8   = pc_plus(if_pc_q, 32'd8);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; expectations follow FETCH_DELAY_SLOT_EN when defined.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .im_req       (im_req),
    .im_addr      (im_addr),
    .im_ready     (im_ready),
    .im_rdata     (im_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc8       (if_pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, cross the active edge, and return on the falling edge.
  task automatic step(input logic rdy, input logic [31:0] a, input logic st,
                      input logic rv, input logic [31:0] rt);
    im_ready     = rdy;
    im_rdata     = rdy ? instr_of(a) : 32'h0;
    stall_i      = st;
    redir_valid  = rv;
    redir_target = rt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b0; stall_i = 1'b0; redir_valid = 1'b0; redir_target = '0;
    im_ready = 1'b0; im_rdata = '0;

    // reset values and zero-wait streaming
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_im_req",   {31'b0, im_req},   32'h0);
    chk("rst_im_addr",  im_addr,           32'h3000);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr,          32'h0);
    chk("rst_if_pc",    if_pc,             32'h0);
    chk("rst_if_pc8",   if_pc8,            32'h8);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("first_req",      {31'b0, im_req}, 32'h1);
    chk("first_addr",     im_addr,         32'h3000);
    chk("first_if_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    chk("zw_addr1",  im_addr,  32'h3004);
    chk("zw_valid1", {31'b0, if_valid}, 32'h1);
    chk("zw_pc1",    if_pc,    32'h3000);
    chk("zw_instr1", if_instr, instr_of(32'h3000));
    step(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    chk("zw_addr2", im_addr, 32'h3008);
    chk("zw_pc2",   if_pc,   32'h3004);
    chk("zw_pc8_2", if_pc8,  32'h300C);

    // three IM wait cycles at 3004
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("lat_addr_hold", im_addr, 32'h3004);
      chk("lat_req_hold",  {31'b0, im_req}, 32'h1);
      chk("lat_no_valid",  {31'b0, if_valid}, 32'h0);
    end
    step(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    chk("lat_valid", {31'b0, if_valid}, 32'h1);
    chk("lat_pc",    if_pc,    32'h3004);
    chk("lat_instr", if_instr, instr_of(32'h3004));
    chk("lat_addr",  im_addr,  32'h3008);
    step(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0);
    chk("lat_pc_next",    if_pc, 32'h3008);
    chk("lat_valid_next", {31'b0, if_valid}, 32'h1);

    // stall for two cycles while the word at 3008 arrives
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3008, 1'b1, 1'b0, 32'h0);
    chk("st_hold_req", {31'b0, im_req}, 32'h0);
    chk("st_hold_pc",  if_pc, 32'h3004);
    chk("st_hold_vld", {31'b0, if_valid}, 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("st_hold_pc2",   if_pc,   32'h3004);
    chk("st_hold_addr2", im_addr, 32'h3008);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("st_out_pc",    if_pc,    32'h3008);
    chk("st_out_instr", if_instr, instr_of(32'h3008));
    chk("st_out_req",   {31'b0, im_req}, 32'h1);
    chk("st_out_addr",  im_addr,  32'h300C);
    step(1'b1, 32'h300C, 1'b0, 1'b0, 32'h0);
    chk("st_next_pc", if_pc, 32'h300C);

    // redirect to 4000 while the branch at 3004 is in D
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3008, 1'b0, 1'b1, 32'h4000);
    chk("rd_slot_valid", {31'b0, if_valid}, {31'b0, DS});
    if (DS) chk("rd_slot_pc", if_pc, 32'h3008);
    chk("rd_addr", im_addr, 32'h4000);
    step(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
    chk("rd_tgt_pc",    if_pc, 32'h4000);
    chk("rd_tgt_valid", {31'b0, if_valid}, 32'h1);
    chk("rd_tgt_addr",  im_addr, 32'h4004);

    // redirect during an IM wait, then overwritten by a second one
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000);
    chk("rw_addr_hold1", im_addr, 32'h3004);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h5000);
    chk("rw_addr_hold2", im_addr, 32'h3004);
    step(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    chk("rw_slot_valid", {31'b0, if_valid}, {31'b0, DS});
    if (DS) chk("rw_slot_pc", if_pc, 32'h3004);
    chk("rw_addr", im_addr, 32'h5000);
    step(1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
    chk("rw_tgt_pc", if_pc, 32'h5000);

    // redirect together with stall is ignored
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3004, 1'b1, 1'b1, 32'h4000);
    chk("rs_hold_req", {31'b0, im_req}, 32'h0);
    chk("rs_hold_pc",  if_pc, 32'h3000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rs_pc",   if_pc,   32'h3004);
    chk("rs_addr", im_addr, 32'h3008);
    step(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0);
    chk("rs_pc2", if_pc, 32'h3008);

    // redirect on the cycle the stall releases a parked word
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3004, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h6000);
    chk("rh_valid", {31'b0, if_valid}, {31'b0, DS});
    if (DS) chk("rh_slot_pc", if_pc, 32'h3004);
    chk("rh_req",  {31'b0, im_req}, 32'h1);
    chk("rh_addr", im_addr, 32'h6000);
    step(1'b1, 32'h6000, 1'b0, 1'b0, 32'h0);
    chk("rh_tgt_pc", if_pc, 32'h6000);

    // PC wraps modulo 2^32
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3004, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wr_valid", {31'b0, if_valid}, {31'b0, DS});
    chk("wr_addr",  im_addr, 32'hFFFF_FFFC);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    chk("wr_pc",       if_pc,   32'hFFFF_FFFC);
    chk("wr_pc8",      if_pc8,  32'h0000_0004);
    chk("wr_addr_zero", im_addr, 32'h0);

    // reset during an IM wait; stale im_ready in S_RST is ignored
    do_reset();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mr_wait_addr", im_addr, 32'h3004);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mr_req",   {31'b0, im_req}, 32'h0);
    chk("mr_addr",  im_addr, 32'h3000);
    chk("mr_valid", {31'b0, if_valid}, 32'h0);
    reset = 1'b1;
    step(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    chk("mr_stale_req",   {31'b0, im_req}, 32'h1);
    chk("mr_stale_addr",  im_addr, 32'h3000);
    chk("mr_stale_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    chk("mr_refetch_pc",   if_pc, 32'h3000);
    chk("mr_refetch_addr", im_addr, 32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
